// File: rtl/timer_counter.sv
// timer_counter
//   Memory-mapped 8-bit (WIDTH) timer/counter. It counts prescaler ticks or
//   raw clocks, compares against two registers (OCRA/OCRB) and supports
//   normal wrap-around and clear-on-compare (CTC) modes. A compare-A match
//   can toggle the oc_a waveform output, and a level interrupt is raised
//   from the enabled flags.
//
// Ports
//   clock, reset          system clock; synchronous active-high reset
//   tick8..tick1024       single-cycle prescaler pulses
//   bus_addr/we/wdata     register write port (one cycle per write)
//   bus_rdata             combinational read data for bus_addr
//   irq                   |(FLAGS & IMSK)
//   oc_a                  compare-A toggle output
//
// Register map
//   0 CTRL  [2:0] CS, [3] CTC, [4] OCA_EN
//   1 CNT   2 OCRA   3 OCRB
//   4 FLAGS [0] TOV, [1] OCFA, [2] OCFB   (write 1 to clear)
//   5 IMSK  [2:0]
//   6-7     read 0, writes ignored
module timer_counter #(
    parameter int WIDTH = 8
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             tick8,
    input  logic             tick64,
    input  logic             tick256,
    input  logic             tick1024,
    input  logic [2:0]       bus_addr,
    input  logic             bus_we,
    input  logic [WIDTH-1:0] bus_wdata,
    output logic [WIDTH-1:0] bus_rdata,
    output logic             irq,
    output logic             oc_a
);

    localparam logic [2:0] A_CTRL  = 3'd0;
    localparam logic [2:0] A_CNT   = 3'd1;
    localparam logic [2:0] A_OCRA  = 3'd2;
    localparam logic [2:0] A_OCRB  = 3'd3;
    localparam logic [2:0] A_FLAGS = 3'd4;
    localparam logic [2:0] A_IMSK  = 3'd5;

    typedef struct packed {
        logic       oca_en;
        logic       ctc;
        logic [2:0] cs;
    } ctrl_t;

    ctrl_t            ctrl;
    logic [WIDTH-1:0] cnt;
    logic [WIDTH-1:0] ocra;
    logic [WIDTH-1:0] ocrb;
    logic [2:0]       flags;
    logic [2:0]       imsk;

    logic             en;
    logic             wr_cnt;
    logic             evt;
    logic             match_a;
    logic             match_b;
    logic             ovf;
    logic [2:0]       flag_set;
    logic [2:0]       flag_clr;

    // Clock-source select; unselected ticks are simply ignored.
    always_comb begin
        en = 1'b0;
        case (ctrl.cs)
            3'd1:    en = 1'b1;
            3'd2:    en = tick8;
            3'd3:    en = tick64;
            3'd4:    en = tick256;
            3'd5:    en = tick1024;
            default: en = 1'b0;
        endcase
    end

    // A CNT write in the same cycle as an enable wins outright: no
    // increment and no compare/overflow events that cycle.
    assign wr_cnt  = bus_we && (bus_addr == A_CNT);
    assign evt     = en && !wr_cnt;
    assign match_a = evt && (cnt == ocra);
    assign match_b = evt && (cnt == ocrb);
    assign ovf     = evt && !ctrl.ctc && (cnt == {WIDTH{1'b1}});

    assign flag_set = {match_b, match_a, ovf};
    assign flag_clr = (bus_we && (bus_addr == A_FLAGS)) ? bus_wdata[2:0] : 3'b000;

    always_ff @(posedge clock) begin
        if (reset) begin
            ctrl  <= '0;
            cnt   <= '0;
            ocra  <= '0;
            ocrb  <= '0;
            flags <= '0;
            imsk  <= '0;
            oc_a  <= 1'b0;
        end else begin
            if (wr_cnt)
                cnt <= bus_wdata;
            else if (en)
                // In CTC a value above OCRA just runs up and wraps silently.
                cnt <= (ctrl.ctc && (cnt == ocra)) ? '0 : cnt + 1'b1;

            if (bus_we) begin
                case (bus_addr)
                    A_CTRL:  ctrl <= bus_wdata[4:0];
                    A_OCRA:  ocra <= bus_wdata;
                    A_OCRB:  ocrb <= bus_wdata;
                    A_IMSK:  imsk <= bus_wdata[2:0];
                    default: ;
                endcase
            end

            // Set beats clear when both hit the same flag in one cycle.
            flags <= (flags & ~flag_clr) | flag_set;

            if (ctrl.oca_en && match_a)
                oc_a <= ~oc_a;
        end
    end

    always_comb begin
        bus_rdata = '0;
        case (bus_addr)
            A_CTRL:  bus_rdata[4:0] = ctrl;
            A_CNT:   bus_rdata      = cnt;
            A_OCRA:  bus_rdata      = ocra;
            A_OCRB:  bus_rdata      = ocrb;
            A_FLAGS: bus_rdata[2:0] = flags;
            A_IMSK:  bus_rdata[2:0] = imsk;
            default: bus_rdata      = '0;
        endcase
    end

    assign irq = |(flags & imsk);

endmodule

// File: tb/tb_timer_counter.sv
module tb_timer_counter;

    logic       clock;
    logic       reset;
    logic       tick8, tick64, tick256, tick1024;
    logic [2:0] bus_addr;
    logic       bus_we;
    logic [7:0] bus_wdata;
    logic [7:0] bus_rdata;
    logic       irq;
    logic       oc_a;

    int n_chk = 0;
    int n_err = 0;

    // Reference model state (plain integers, one per architectural register)
    int m_cs, m_ctc, m_oce, m_cnt, m_ocra, m_ocrb, m_flags, m_imsk, m_oca;

    timer_counter #(.WIDTH(8)) dut (
        .clock    (clock),
        .reset    (reset),
        .tick8    (tick8),
        .tick64   (tick64),
        .tick256  (tick256),
        .tick1024 (tick1024),
        .bus_addr (bus_addr),
        .bus_we   (bus_we),
        .bus_wdata(bus_wdata),
        .bus_rdata(bus_rdata),
        .irq      (irq),
        .oc_a     (oc_a)
    );

    initial clock = 1'b0;
    always #10 clock = ~clock;

    function automatic int mread(input int a);
        case (a)
            0: return m_cs + 8 * m_ctc + 16 * m_oce;
            1: return m_cnt;
            2: return m_ocra;
            3: return m_ocrb;
            4: return m_flags;
            5: return m_imsk;
            default: return 0;
        endcase
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    // One clock: evaluate the model from the inputs present at the edge,
    // then advance to just after the edge.
    task automatic step();
        int en, wc, ev, sa, sb, so, clr, a, d;
        int n_cs, n_ctc, n_oce, n_cnt, n_ocra, n_ocrb, n_flags, n_imsk, n_oca;
        a = int'(bus_addr);
        d = int'(bus_wdata);
        case (m_cs)
            1: en = 1;
            2: en = int'(tick8);
            3: en = int'(tick64);
            4: en = int'(tick256);
            5: en = int'(tick1024);
            default: en = 0;
        endcase
        n_cs = m_cs; n_ctc = m_ctc; n_oce = m_oce; n_cnt = m_cnt; n_ocra = m_ocra;
        n_ocrb = m_ocrb; n_flags = m_flags; n_imsk = m_imsk; n_oca = m_oca;
        if (reset) begin
            n_cs = 0; n_ctc = 0; n_oce = 0; n_cnt = 0; n_ocra = 0;
            n_ocrb = 0; n_flags = 0; n_imsk = 0; n_oca = 0;
        end else begin
            wc = (bus_we && a == 1) ? 1 : 0;
            ev = (en != 0 && wc == 0) ? 1 : 0;
            sa = (ev != 0 && m_cnt == m_ocra) ? 1 : 0;
            sb = (ev != 0 && m_cnt == m_ocrb) ? 1 : 0;
            so = (ev != 0 && m_ctc == 0 && m_cnt == 255) ? 1 : 0;
            if (wc != 0) n_cnt = d;
            else if (en != 0) n_cnt = (m_ctc != 0 && m_cnt == m_ocra) ? 0 : (m_cnt + 1) % 256;
            clr = (bus_we && a == 4) ? (d % 8) : 0;
            n_flags = (m_flags & ~clr) | so | (sa * 2) | (sb * 4);
            if (m_oce != 0 && sa != 0) n_oca = 1 - m_oca;
            if (bus_we) begin
                case (a)
                    0: begin n_cs = d % 8; n_ctc = (d / 8) % 2; n_oce = (d / 16) % 2; end
                    2: n_ocra = d;
                    3: n_ocrb = d;
                    5: n_imsk = d % 8;
                    default: ;
                endcase
            end
        end
        @(posedge clock);
        #1;
        m_cs = n_cs; m_ctc = n_ctc; m_oce = n_oce; m_cnt = n_cnt; m_ocra = n_ocra;
        m_ocrb = n_ocrb; m_flags = n_flags; m_imsk = n_imsk; m_oca = n_oca;
    endtask

    task automatic wr(input int a, input int d);
        bus_addr  = 3'(a);
        bus_wdata = 8'(d);
        bus_we    = 1'b1;
        step();
        bus_we    = 1'b0;
    endtask

    task automatic rd_chk(input int a, input int exp, input int mask, input string name);
        bus_addr = 3'(a);
        #1;
        chk(name, int'(bus_rdata) & mask, exp);
    endtask

    task automatic reset_dut();
        reset = 1'b1;
        step();
        reset = 1'b0;
    endtask

    typedef struct {
        int addr;
        int wdata;
        int exp;
    } vec_t;

    vec_t tbl[10];

    initial begin
        reset = 1'b1; tick8 = 0; tick64 = 0; tick256 = 0; tick1024 = 0;
        bus_addr = 0; bus_we = 0; bus_wdata = 0;
        m_cs = 0; m_ctc = 0; m_oce = 0; m_cnt = 0; m_ocra = 0;
        m_ocrb = 0; m_flags = 0; m_imsk = 0; m_oca = 0;

        // Reset state
        step(); step();
        reset = 1'b0;
        for (int a = 0; a < 8; a++) rd_chk(a, 0, 8'hFF, "reset_read");
        chk("reset_irq", int'(irq), 0);
        chk("reset_oca", int'(oc_a), 0);

        // Register map write/read-back (CS stays in a stopped code)
        tbl[0] = '{0, 8'hFE, 8'h1E};
        tbl[1] = '{1, 8'hA5, 8'hA5};
        tbl[2] = '{2, 8'h3C, 8'h3C};
        tbl[3] = '{3, 8'hC3, 8'hC3};
        tbl[4] = '{4, 8'hFF, 8'h00};
        tbl[5] = '{5, 8'hFF, 8'h07};
        tbl[6] = '{6, 8'hFF, 8'h00};
        tbl[7] = '{7, 8'hFF, 8'h00};
        tbl[8] = '{0, 8'hFF, 8'h1F};
        tbl[9] = '{0, 8'h00, 8'h00};
        for (int i = 0; i < 10; i++) begin
            wr(tbl[i].addr, tbl[i].wdata);
            rd_chk(tbl[i].addr, tbl[i].exp, 8'hFF, "regmap");
            chk("regmap_irq", int'(irq), 0);
        end
        rd_chk(1, 8'hA5, 8'hFF, "cnt_held_stopped");

        // Normal overflow
        reset_dut();
        wr(5, 1); wr(1, 8'hFD); wr(0, 8'h01);
        step(); step(); step();
        rd_chk(1, 8'h00, 8'hFF, "ovf_cnt");
        rd_chk(4, 8'h01, 8'hFF, "ovf_flags");
        chk("ovf_irq", int'(irq), 1);
        // CNT==0 matches OCRA=OCRB=0 during the clear cycle
        wr(4, 8'h01);
        rd_chk(4, 8'h06, 8'hFF, "tov_cleared");
        chk("tov_irq_low", int'(irq), 0);
        rd_chk(1, 8'h01, 8'hFF, "cnt_after_clr");
        step();
        rd_chk(1, 8'h02, 8'hFF, "cnt_keeps_going");

        // CTC with OCA toggle
        reset_dut();
        wr(2, 4); wr(0, 8'h19);
        for (int k = 1; k <= 600; k++) begin
            step();
            if (k <= 10 || k == 600) begin
                rd_chk(1, k % 5, 8'hFF, "ctc_cnt");
                chk("ctc_oca", int'(oc_a), (k / 5) % 2);
            end
            if (k == 4) rd_chk(4, 0, 2, "ctc_ocfa_early");
            if (k == 5) rd_chk(4, 2, 2, "ctc_ocfa_set");
        end
        rd_chk(4, 0, 1, "ctc_no_tov");

        // Prescaled source: only tick64 counts
        reset_dut();
        wr(0, 3);
        for (int p = 0; p < 10; p++) begin
            for (int c = 0; c < 64; c++) begin
                tick64   = (c == 63);
                tick8    = 1'($urandom % 2);
                tick256  = 1'($urandom % 2);
                tick1024 = 1'($urandom % 2);
                step();
            end
            rd_chk(1, p + 1, 8'hFF, "presc_cnt");
        end
        tick64 = 0;
        wr(0, 0);
        for (int c = 0; c < 200; c++) begin
            tick64 = 1'($urandom % 2);
            tick8  = 1'($urandom % 2);
            step();
        end
        tick64 = 0; tick8 = 0; tick256 = 0; tick1024 = 0;
        rd_chk(1, 10, 8'hFF, "presc_frozen");

        // CNT write collides with an enable while CNT==OCRA
        reset_dut();
        wr(2, 5); wr(1, 5); wr(0, 1);
        wr(1, 8'h10);
        rd_chk(1, 8'h10, 8'hFF, "coll_cnt");
        rd_chk(4, 0, 2, "coll_ocfa");

        // OCFB set concurrent with its W1C
        reset_dut();
        wr(3, 3); wr(1, 3); wr(0, 1);
        wr(4, 8'h04);
        rd_chk(4, 4, 4, "coll_ocfb");

        // OCRA == OCRB sets both flags together
        reset_dut();
        wr(2, 7); wr(3, 7); wr(1, 7); wr(0, 1);
        step();
        rd_chk(4, 6, 8'hFF, "both_flags");

        // Reset mid-operation
        reset_dut();
        wr(2, 8'h80); wr(1, 8'h80); wr(5, 7); wr(0, 8'h11);
        step();
        chk("mid_oca_set", int'(oc_a), 1);
        chk("mid_irq_set", int'(irq), 1);
        reset_dut();
        for (int a = 0; a < 8; a++) rd_chk(a, 0, 8'hFF, "mid_reset_read");
        chk("mid_reset_irq", int'(irq), 0);
        chk("mid_reset_oca", int'(oc_a), 0);

        // Randomized traffic against the model
        for (int i = 0; i < 3000; i++) begin
            int a;
            reset    = ($urandom % 300 == 0);
            tick8    = ($urandom % 4 == 0);
            tick64   = ($urandom % 4 == 0);
            tick256  = ($urandom % 4 == 0);
            tick1024 = ($urandom % 4 == 0);
            bus_we   = ($urandom % 4 == 0);
            bus_addr = 3'($urandom % 8);
            if ((bus_addr == 2 || bus_addr == 3 || bus_addr == 1) && ($urandom % 2 == 1))
                bus_wdata = 8'($urandom % 12);
            else
                bus_wdata = 8'($urandom);
            step();
            bus_we = 0;
            reset  = 0;
            a = int'($urandom % 8);
            rd_chk(a, mread(a), 8'hFF, "rand_rdata");
            chk("rand_irq", int'(irq), ((m_flags & m_imsk) != 0) ? 1 : 0);
            chk("rand_oca", int'(oc_a), m_oca);
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule

// File: doc/timer_counter.md
# timer_counter

Memory-mapped timer/counter that consumes the single-cycle tick pulses produced by the clock prescaler. It provides an up-counter with a selectable clock source, two compare registers, normal and clear-on-compare (CTC) modes, a compare-A output toggle and a maskable interrupt. It sits between the prescaler and the CPU peripheral bus and supplies the Arduino-style millis/PWM/timer-interrupt services.

## Interface
- WIDTH, 8, counter, compare and data register width.

- clock  in  1  system clock.
- reset  in  1  synchronous, active-high.
- tick8  in  1  prescaler pulse, high 1 cycle every 8 clocks.
- tick64  in  1  prescaler pulse, high 1 cycle every 64 clocks.
- tick256  in  1  prescaler pulse, high 1 cycle every 256 clocks.
- tick1024  in  1  prescaler pulse, high 1 cycle every 1024 clocks.
- bus_addr  in  3  register select.
- bus_we  in  1  write strobe, 1 cycle per write.
- bus_wdata  in  WIDTH  write data.
- bus_rdata  out  WIDTH  read data, combinational from bus_addr.
- irq  out  1  interrupt request, level.
- oc_a  out  1  compare-A waveform output.

## Operation
- Register map:
  - 0 CTRL: [2:0] CS, [3] CTC, [4] OCA_EN, rest read 0.
  - 1 CNT.
  - 2 OCRA.
  - 3 OCRB.
  - 4 FLAGS: [0] TOV, [1] OCFA, [2] OCFB. Write 1 to clear, write 0 no effect.
  - 5 IMSK: [2:0] enable per flag.
  - 6–7 read 0; writes ignored.
- CS selects the count enable `en`:
  - 0: stopped.
  - 1: every clock.
  - 2: tick8.
  - 3: tick64.
  - 4: tick256.
  - 5: tick1024.
  - 6 and 7: stopped.
  - Ticks not selected are ignored.
- On `en`, compares use the CNT value before update:
  - CNT==OCRA sets OCFA.
  - CNT==OCRB sets OCFB.
  - If OCA_EN, oc_a toggles on each OCFA set event.
- Normal mode (CTC=0), on `en`:
  - CNT <= CNT+1, modulo 2^WIDTH.
  - The transition from all-ones to 0 sets TOV.
- CTC mode (CTC=1), on `en`:
  - If CNT==OCRA, CNT <= 0; otherwise CNT+1.
  - TOV is never set in CTC mode.
  - If CNT > OCRA, the counter runs to all-ones, wraps to 0 without setting TOV, then matches.
- irq = |(FLAGS[2:0] & IMSK[2:0]).

## Timing
- Reset values: all registers 0, oc_a 0, irq 0, bus_rdata 0 for every address.
- CNT and flag latency: an enable pulse in cycle t gives the updated CNT and flags after the clock edge ending cycle t. They are readable on bus_rdata in cycle t+1.
- irq latency: irq is combinational from FLAGS/IMSK, so it rises in cycle t+1 with no further delay.
- Register writes take effect at the edge. A new CS or CTC value governs the next cycle's `en`.
- Simultaneous events:
  - CNT write and `en` in the same cycle: the written value wins, there is no increment, and no compare or overflow flag is set that cycle.
  - Flag set event and W1C of the same flag in the same cycle: the set wins and the flag stays 1.
  - OCRA write and `en` in the same cycle: the compare uses the old OCRA.
  - OCRA==OCRB: both flags set in the same cycle.
- reset mid-count returns everything to reset values at the next edge, including oc_a. Ticks during reset are ignored.

## Test plan
- Reset: assert reset 2 cycles, then read addresses 0–7. Required: all read 0, irq=0, oc_a=0.
- Normal overflow:
  - Stimulus: IMSK=1, CNT=0xFD, CTRL=0x01.
  - Required: after 3 clocks CNT=0x00, TOV=1, irq=1.
  - Then write FLAGS=0x01. Required: TOV=0, irq=0 next cycle, CNT keeps counting.
- CTC:
  - Stimulus: OCRA=4, CTRL=0x19 (CS=1, CTC, OCA_EN).
  - Required: CNT cycles 0,1,2,3,4,0; OCFA set every 5 clocks; oc_a period 10 clocks; TOV stays 0 for 600 clocks.
- Prescaled source:
  - Stimulus: CS=3; drive tick64 every 64 clocks, plus random tick8/tick256 pulses.
  - Required: CNT advances exactly once per tick64 pulse. After 10 pulses CNT=10.
  - Then set CS=0. Required: CNT frozen.
- Collisions:
  - Write CNT=0x10 in the same cycle as an enable with CNT==OCRA. Required: CNT=0x10 next cycle, OCFA unchanged.
  - Force an OCFB set concurrent with W1C of OCFB. Required: OCFB=1.
- Reset mid-operation: with CS=1, CNT=0x80, OCFA=1, oc_a=1, assert reset for 1 cycle. Required: all registers 0, irq=0, oc_a=0 the following cycle.
